// File: rtl/regfile_mp.sv
// Multi-port register file: 2 combinational reads, 2 synchronous writes, pending-write scoreboard.
// Optional same-cycle write forwarding to the read ports via REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int unsigned width     = 32,
  parameter int unsigned addr_bits = 5,
  parameter bit          zero_reg  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [addr_bits-1:0] A_addr,
  input  logic [addr_bits-1:0] B_addr,
  output logic [width-1:0]     A_data,
  output logic [width-1:0]     B_data,
  output logic                 A_busy,
  output logic                 B_busy,
  input  logic [addr_bits-1:0] W0_addr,
  input  logic [addr_bits-1:0] W1_addr,
  input  logic [width-1:0]     W0_data,
  input  logic [width-1:0]     W1_data,
  input  logic                 W0_enable,
  input  logic                 W1_enable,
  input  logic                 iss_enable,
  input  logic [addr_bits-1:0] iss_addr,
  output logic [addr_bits:0]   busy_count
);

  localparam int unsigned Depth = 1 << addr_bits;
  localparam int unsigned CntW  = addr_bits + 1;

  logic [width-1:0]     mem_q [Depth];
  logic [width-1:0]     mem_d [Depth];
  logic [Depth-1:0]     busy_q, busy_d;
  logic [addr_bits:0]   count_q, count_d;

  logic [addr_bits-1:0] rd_addr [2];
  logic [width-1:0]     rd_data [2];
  logic                 rd_busy [2];

  // W1 is applied after W0 so it wins a same-address collision; issue is applied last so it
  // wins over a same-cycle write to the same register.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (W0_enable) begin
      mem_d[W0_addr]  = W0_data;
      busy_d[W0_addr] = 1'b0;
    end
    if (W1_enable) begin
      mem_d[W1_addr]  = W1_data;
      busy_d[W1_addr] = 1'b0;
    end
    if (iss_enable) begin
      busy_d[iss_addr] = 1'b1;
    end
    if (zero_reg) begin
      mem_d[0]  = '0;
      busy_d[0] = 1'b0;
    end
    count_d = '0;
    for (int i = 0; i < Depth; i++) begin
      count_d = count_d + CntW'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign rd_addr[0] = A_addr;
  assign rd_addr[1] = B_addr;

`ifdef REGFILE_BYPASS_EN
  logic wr_hit;
`endif

  always_comb begin
`ifdef REGFILE_BYPASS_EN
    wr_hit = 1'b0;
`endif
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = mem_q[rd_addr[p]];
      rd_busy[p] = busy_q[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
      wr_hit = (W0_enable && W0_addr == rd_addr[p]) || (W1_enable && W1_addr == rd_addr[p]);
      if (W1_enable && W1_addr == rd_addr[p]) begin
        rd_data[p] = W1_data;
      end else if (W0_enable && W0_addr == rd_addr[p]) begin
        rd_data[p] = W0_data;
      end
      if (wr_hit && !(iss_enable && iss_addr == rd_addr[p])) begin
        rd_busy[p] = 1'b0;
      end
`endif
      if ((zero_reg && rd_addr[p] == '0) || !reset) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end
    end
  end

  assign A_data     = rd_data[0];
  assign B_data     = rd_data[1];
  assign A_busy     = rd_busy[0];
  assign B_busy     = rd_busy[1];
  assign busy_count = reset ? count_q : '0;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed table, hand sequences and random traffic
// against an array-based reference model.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  A_addr = '0, B_addr = '0, W0_addr = '0, W1_addr = '0, iss_addr = '0;
  logic [31:0] A_data, B_data, W0_data = '0, W1_data = '0;
  logic        A_busy, B_busy, W0_enable = 1'b0, W1_enable = 1'b0, iss_enable = 1'b0;
  logic [5:0]  busy_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem  [32];
  bit          m_busy [32];

  regfile_mp #(.width(32), .addr_bits(5), .zero_reg(1'b1)) dut (
    .clk(clk), .reset(reset),
    .A_addr(A_addr), .B_addr(B_addr), .A_data(A_data), .B_data(B_data),
    .A_busy(A_busy), .B_busy(B_busy),
    .W0_addr(W0_addr), .W1_addr(W1_addr), .W0_data(W0_data), .W1_data(W1_data),
    .W0_enable(W0_enable), .W1_enable(W1_enable),
    .iss_enable(iss_enable), .iss_addr(iss_addr), .busy_count(busy_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w0e; logic [4:0] w0a; logic [31:0] w0d;
    logic        w1e; logic [4:0] w1a; logic [31:0] w1d;
    logic        ise; logic [4:0] isa;
    logic [4:0]  aa;  logic [4:0] ba;
    logic [31:0] exp_a; logic [31:0] exp_b; logic exp_abusy; logic [5:0] exp_cnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (!reset || a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (W1_enable && W1_addr == a) return W1_data;
    if (W0_enable && W0_addr == a) return W0_data;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (!reset || a == 5'd0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (((W0_enable && W0_addr == a) || (W1_enable && W1_addr == a)) &&
        !(iss_enable && iss_addr == a)) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Spec rules at a clock edge: W0 then W1 (W1 wins), writes clear, issue sets; r0 untouchable.
  task automatic model_edge();
    if (W0_enable && W0_addr != 0) begin m_mem[W0_addr] = W0_data; m_busy[W0_addr] = 1'b0; end
    if (W1_enable && W1_addr != 0) begin m_mem[W1_addr] = W1_data; m_busy[W1_addr] = 1'b0; end
    if (iss_enable && iss_addr != 0) m_busy[iss_addr] = 1'b1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".A_data"}, A_data, exp_data(A_addr));
    chk({tag, ".B_data"}, B_data, exp_data(B_addr));
    chk({tag, ".A_busy"}, {31'd0, A_busy}, {31'd0, exp_busy(A_addr)});
    chk({tag, ".B_busy"}, {31'd0, B_busy}, {31'd0, exp_busy(B_addr)});
    chk({tag, ".busy_count"}, {26'd0, busy_count}, reset ? pending() : 0);
  endtask

  task automatic drive(input vec_t v);
    W0_enable = v.w0e; W0_addr = v.w0a; W0_data = v.w0d;
    W1_enable = v.w1e; W1_addr = v.w1a; W1_data = v.w1d;
    iss_enable = v.ise; iss_addr = v.isa;
    A_addr = v.aa; B_addr = v.ba;
  endtask

  // Clock edge, then strobes drop so the post-edge read shows stored state only.
  task automatic finish_cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    W0_enable = 1'b0; W1_enable = 1'b0; iss_enable = 1'b0;
    #1;
    check_model({tag, ".post"});
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    #1;
    check_model({tag, ".pre"});
    finish_cycle(tag);
    chk({tag, ".tab_A"}, A_data, v.exp_a);
    chk({tag, ".tab_B"}, B_data, v.exp_b);
    chk({tag, ".tab_Abusy"}, {31'd0, A_busy}, {31'd0, v.exp_abusy});
    chk({tag, ".tab_cnt"}, {26'd0, busy_count}, {26'd0, v.exp_cnt});
  endtask

  vec_t tab [10];
  vec_t v;

  initial begin
    model_reset();
    //            w0e w0a  w0d            w1e w1a  w1d           ise isa  aa  ba  expA          expB          bsy cnt
    tab[0] = '{1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 3, 4, 32'h11, 32'h22, 0, 0};
    tab[1] = '{1, 7, 32'hAA, 1, 7, 32'hBB, 0, 0, 7, 3, 32'hBB, 32'h11, 0, 0};
    tab[2] = '{1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 32'h0, 32'h0, 0, 0};
    tab[3] = '{0, 0, 32'h0, 0, 0, 32'h0, 1, 9, 9, 0, 32'h0, 32'h0, 1, 1};
    tab[4] = '{0, 0, 32'h0, 0, 0, 32'h0, 1, 9, 9, 7, 32'h0, 32'hBB, 1, 1};
    tab[5] = '{0, 0, 32'h0, 1, 9, 32'h77, 1, 9, 9, 4, 32'h77, 32'h22, 1, 1};
    tab[6] = '{1, 9, 32'h99, 0, 0, 32'h0, 0, 0, 9, 9, 32'h99, 32'h99, 0, 0};
    tab[7] = '{1, 2, 32'h5, 0, 0, 32'h0, 0, 0, 2, 0, 32'h5, 32'h0, 0, 0};
    tab[8] = '{1, 1, 32'h31, 0, 0, 32'h0, 1, 1, 1, 2, 32'h31, 32'h5, 1, 1};
    tab[9] = '{0, 0, 32'h0, 1, 1, 32'h41, 0, 0, 1, 1, 32'h41, 32'h41, 0, 0};

    // Reset state while reset is held low
    A_addr = 5'd5; B_addr = 5'd31;
    #3;
    check_model("rst_hold");
    chk("rst_hold.count_zero", {26'd0, busy_count}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(tab[i], $sformatf("vec%0d", i));

    // Bypass: r2 holds 0x5, W0 writes 0x9 while A reads r2
    @(negedge clk);
    v = '{1, 2, 32'h9, 0, 0, 32'h0, 0, 0, 2, 2, 32'h0, 32'h0, 0, 0};
    drive(v);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass.pre_A", A_data, 32'h9);
`else
    chk("bypass.pre_A", A_data, 32'h5);
`endif
    finish_cycle("bypass");
    chk("bypass.post_A", A_data, 32'h9);

    // Asynchronous reset mid-cycle after r5 gets 0xDEADBEEF and r6 is issued
    v = '{1, 5, 32'hDEADBEEF, 0, 0, 32'h0, 1, 6, 5, 6, 32'hDEADBEEF, 32'h0, 0, 1};
    run_vec(v, "pre_rst");
    @(negedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_rst.A_r5", A_data, 32'h0);
    chk("async_rst.B_busy_r6", {31'd0, B_busy}, 32'd0);
    chk("async_rst.count", {26'd0, busy_count}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    v = '{1, 5, 32'h1, 0, 0, 32'h0, 0, 0, 5, 6, 32'h1, 32'h0, 0, 0};
    run_vec(v, "post_rst");

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      W0_enable  = ($urandom_range(0, 9) < 4);
      W1_enable  = ($urandom_range(0, 9) < 4);
      iss_enable = ($urandom_range(0, 9) < 5);
      W0_addr  = 5'($urandom_range(0, 15));
      W1_addr  = 5'($urandom_range(0, 15));
      iss_addr = 5'($urandom_range(0, 15));
      A_addr   = ($urandom_range(0, 1) == 0) ? W0_addr : 5'($urandom_range(0, 31));
      B_addr   = ($urandom_range(0, 1) == 0) ? iss_addr : 5'($urandom_range(0, 31));
      W0_data  = $urandom;
      W1_data  = $urandom;
      #1;
      check_model("rnd.pre");
      finish_cycle("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file: two combinational read ports, two synchronous write ports and a per-register pending-write scoreboard. It is the next-generation replacement for the single-write-port 32x32 register file in the core datapath. Depth, width and zero-register handling are configurable. It serves dual-issue writeback and hazard detection in the decode stage.

## Interface
- width, 32, data bits per register
- addr_bits, 5, address width; depth = 2^addr_bits registers
- zero_reg, 1, when 1 register 0 reads as zero, ignores writes and is never busy

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- A_addr, B_addr  in  addr_bits  read addresses
- A_data, B_data  out  width  read data
- A_busy, B_busy  out  1  addressed register has a pending write
- W0_addr, W1_addr  in  addr_bits  write addresses
- W0_data, W1_data  in  width  write data
- W0_enable, W1_enable  in  1  write strobes
- iss_enable  in  1  mark iss_addr as pending (producer issued)
- iss_addr  in  addr_bits  destination being issued
- busy_count  out  addr_bits+1  number of registers currently pending

## Operation
- Storage: 2^addr_bits registers of width bits. Writes occur on the rising clk edge when the write enable is high.
- Both writes target the same address in one cycle: W1_data is stored and W0 is dropped.
- Different addresses: both writes are stored in the same edge.
- zero_reg=1:
  - writes and issues to address 0 are ignored.
  - A_data/B_data for address 0 = 0; A_busy/B_busy = 0.
- Scoreboard: one busy bit per register.
  - Set on an edge where iss_enable=1 for iss_addr.
  - Cleared on an edge where either write port writes that address.
  - Issue and write to the same address in one cycle: issue wins, so the bit ends set (a new producer is outstanding).
  - Issue to an already-busy register: the bit stays set, and busy_count does not change.
- busy_count: registered population count of the busy bits. It is updated in the same edge as the bits and never exceeds depth (or depth-1 with zero_reg=1).
- Reads are combinational from addr to data. With REGFILE_BYPASS_EN, the same-cycle write data is forwarded (see Configuration).

## Timing
- Reset (reset=0) is asynchronous. While it is low:
  - all registers = 0, all busy bits = 0, busy_count = 0
  - A_data/B_data = 0 for any address; A_busy/B_busy = 0
- Reset asserted mid-operation discards pending writes and issues immediately. The first write after release is accepted on the first rising edge with reset=1.
- Write latency: data written at edge N is visible on the read ports after edge N (same cycle as the write only with bypass).
- Scoreboard latency: a busy bit set or cleared at edge N is reflected in A_busy/B_busy and busy_count after edge N.
- No handshake or backpressure exists. Every strobe is accepted in the cycle it is high.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A_data returns W1_data if W1_enable && W1_addr==A_addr. Otherwise it returns W0_data if W0_enable && W0_addr==A_addr. Otherwise it returns the stored value. B is handled the same way.
  - A_busy/B_busy = stored bit && !(a write hits that address this cycle && !(iss_enable && iss_addr==addr)).
  - Bypass never applies to register 0 when zero_reg=1.
- REGFILE_BYPASS_EN undefined:
  - read data and busy come from stored state only; a same-cycle write is visible the next cycle.

## Test plan
- Reset behaviour: write 0xDEADBEEF to r5, then drop reset asynchronously mid-cycle -> A_data(r5)=0 and busy_count=0 before the next edge. After release, write 0x1 to r5 -> A_data=0x1.
- Dual write:
  - W0 r3=0x11 and W1 r4=0x22 in one edge -> r3=0x11, r4=0x22.
  - Next edge, W0 r7=0xAA and W1 r7=0xBB -> r7=0xBB.
- Zero register (zero_reg=1): write r0=0xFFFFFFFF and issue r0 -> A_data(r0)=0, A_busy=0, busy_count unchanged.
- Scoreboard:
  - Issue r9 -> busy_count=1, A_busy(r9)=1.
  - Issue r9 again -> count stays 1.
  - Issue r9 and W1 r9 in the same cycle -> bit stays 1.
  - Next edge, W0 r9 -> busy 0, count=0.
- Bypass: with r2=0x5, drive W0 r2=0x9 with A_addr=r2 during the cycle -> A_data=0x9 with the macro defined, 0x5 without it. In both cases A_data=0x9 after the edge.
